// File: rtl/robs_pkg.sv
// Shared types and control-word encodings for the Robertson multiplier
// controller and its control-word decoder.
package robs_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_LOADR,
        S_TEST,
        S_ADD,
        S_SUB,
        S_SHIFT,
        S_WRITE,
        S_STORE,
        S_DONE,
        S_ERR
    } robs_state_t;

    localparam int C_W          = 15;

    localparam int C_LOAD_Y     = 0;
    localparam int C_CNT_RST    = 1;
    localparam int C_CLR_A      = 2;
    localparam int C_LOAD_X     = 3;
    localparam int C_RH_SEL     = 4;
    localparam int C_RL_SEL     = 6;
    localparam int C_X_SEL      = 7;
    localparam int C_LOAD_RH    = 8;
    localparam int C_LOAD_RL    = 9;
    localparam int C_ADDSUB     = 10;
    localparam int C_SHIFT_MODE = 11;
    localparam int C_SHIFT_EN   = 12;
    localparam int C_CNT_DEC    = 13;
    localparam int C_LOAD_A     = 14;

    localparam logic [1:0] RH_A   = 2'b00;
    localparam logic [1:0] RH_SR  = 2'b01;
    localparam logic [1:0] RH_ALU = 2'b10;

    localparam logic ADDSUB_ADD  = 1'b1;
    localparam logic ADDSUB_SUB  = 1'b0;
    localparam logic SHIFT_ARITH = 1'b1;

endpackage

// File: rtl/robs_control_cword_decode.sv
// Moore decode of the controller state into the 15-bit datapath
// control word; bits not named for a state stay 0.
module robs_cword_decode
    import robs_pkg::*;
(
    input  robs_state_t      state,
    output logic [C_W-1:0]   c
);

    always_comb begin
        c = '0;
        unique case (state)
            S_INIT: begin
                c[C_LOAD_Y]  = 1'b1;
                c[C_CNT_RST] = 1'b1;
                c[C_CLR_A]   = 1'b1;
                c[C_LOAD_X]  = 1'b1;
                c[C_X_SEL]   = 1'b0;
            end
            S_LOADR: begin
                c[C_RH_SEL +: 2] = RH_A;
                c[C_RL_SEL]      = 1'b0;
                c[C_LOAD_RH]     = 1'b1;
                c[C_LOAD_RL]     = 1'b1;
            end
            S_ADD: begin
                c[C_RH_SEL +: 2] = RH_ALU;
                c[C_ADDSUB]      = ADDSUB_ADD;
                c[C_LOAD_RH]     = 1'b1;
            end
            S_SUB: begin
                c[C_RH_SEL +: 2] = RH_ALU;
                c[C_ADDSUB]      = ADDSUB_SUB;
                c[C_LOAD_RH]     = 1'b1;
            end
            S_SHIFT: begin
                c[C_SHIFT_EN]   = 1'b1;
                c[C_SHIFT_MODE] = SHIFT_ARITH;
            end
            S_WRITE: begin
                c[C_RH_SEL +: 2] = RH_SR;
                c[C_RL_SEL]      = 1'b1;
                c[C_LOAD_RH]     = 1'b1;
                c[C_LOAD_RL]     = 1'b1;
                c[C_CNT_DEC]     = 1'b1;
            end
            S_STORE: begin
                c[C_LOAD_A] = 1'b1;
                c[C_LOAD_X] = 1'b1;
                c[C_X_SEL]  = 1'b1;
            end
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/robs_control.sv
// Sequencer for the signed Robertson multiplier datapath.
// Define ROBS_CTRL_WATCHDOG_EN to add the iteration watchdog and ERR state.
module robs_control
    import robs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             zr,
    input  logic             zq,
    output logic [C_W-1:0]   c,
    output logic             busy,
    output logic             done,
    output logic             err
);

    robs_state_t state_q;
    robs_state_t state_d;
    logic        last_q;
    logic        wd_trip;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_TEST)
                last_q <= zq;
        end
    end

`ifdef ROBS_CTRL_WATCHDOG_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] iter_q;

    always_ff @(posedge clk) begin
        if (reset)
            iter_q <= '0;
        else if (state_q == S_INIT)
            iter_q <= '0;
        else if (state_q == S_WRITE)
            iter_q <= iter_q + 1'b1;
    end

    // The WRITE in progress is iteration iter_q+1; trip on the WIDTH-th
    // one if the sign-bit iteration was never seen.
    assign wd_trip = (iter_q == CNT_W'(WIDTH - 1)) && !last_q;
`else
    // A zero-width multiplier can never finish; otherwise never trips.
    assign wd_trip = (WIDTH < 1);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT:  state_d = S_LOADR;
            S_LOADR: state_d = S_TEST;
            S_TEST: begin
                if (zr)
                    state_d = S_SHIFT;
                else if (zq)
                    state_d = S_SUB;
                else
                    state_d = S_ADD;
            end
            S_ADD:   state_d = S_SHIFT;
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: state_d = S_WRITE;
            S_WRITE: begin
                if (last_q)
                    state_d = S_STORE;
                else if (wd_trip)
                    state_d = S_ERR;
                else
                    state_d = S_TEST;
            end
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
`ifdef ROBS_CTRL_WATCHDOG_EN
        err  = (state_q == S_ERR);
`else
        err  = 1'b0;
`endif
    end

    robs_cword_decode u_decode (
        .state (state_q),
        .c     (c)
    );

endmodule

// File: tb/tb_robs_control.sv
// Bench for robs_control driving a behavioural Robertson datapath;
// results are checked against signed products and cycle formulas.
module tb_robs_control;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        zr;
    logic        zq;
    logic [14:0] c;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run = 0;
    int fails = 0;

    int done_cnt = 0;
    int err_cnt = 0;
    int add_cnt = 0;
    int sub_cnt = 0;
    int wr_cnt = 0;

    logic [7:0]        mplier = '0;
    logic [7:0]        mcand = '0;
    bit                force_zq0 = 1'b0;
    logic [7:0]        y = '0;
    logic [7:0]        x = '0;
    logic [7:0]        a = '0;
    logic signed [8:0] rh = '0;
    logic [7:0]        rl = '0;
    logic [16:0]       sr = '0;
    int                cnt = 0;

    always #5 clk = ~clk;

    robs_control #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .zr    (zr),
        .zq    (zq),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // Behavioural datapath: 9-bit accumulator so add/sub never overflows.
    assign zr = ~rl[0];
    assign zq = (cnt == 0) && !force_zq0;

    always @(posedge clk) begin
        if (c[0]) y <= mcand;
        if (c[1]) cnt <= W - 1;
        else if (c[13]) cnt <= cnt - 1;
        if (c[2]) a <= '0;
        else if (c[14]) a <= rh[7:0];
        if (c[3]) x <= c[7] ? rl : mplier;
        if (c[12])
            sr <= c[11] ? 17'($signed({rh, rl}) >>> 1) : ({rh, rl} >> 1);
        if (c[8]) begin
            case (c[5:4])
                2'b00:   rh <= $signed({a[7], a});
                2'b01:   rh <= $signed(sr[16:8]);
                2'b10:   rh <= c[10] ? rh + $signed({y[7], y})
                                     : rh - $signed({y[7], y});
                default: rh <= rh;
            endcase
        end
        if (c[9]) rl <= c[6] ? sr[7:0] : x;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (c[8] && c[5:4] == 2'b10) begin
            if (c[10]) add_cnt++;
            else sub_cnt++;
        end
        if (c[13]) wr_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        add_cnt = 0;
        sub_cnt = 0;
        wr_cnt = 0;
    endtask

    task automatic run_op(input logic [7:0] mp, input logic [7:0] mc,
                          output int cyc, output logic [15:0] prod,
                          output bit to);
        tick();
        mplier = mp;
        mcand = mc;
        clear_counts();
        start = 1'b1;
        cyc = 0;
        to = 1'b1;
        prod = 'x;
        for (int k = 0; k < 200; k++) begin
            tick();
            start = 1'b0;
            cyc++;
            if (done) begin
                to = 1'b0;
                prod = {a, x};
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if (c !== 15'h0) begin
            fails++;
            $display("FAIL reset_c got=%h exp=0000", c);
        end
        tests_run++;
        if ({busy, done, err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=000", {busy, done, err});
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic check_op(input string nm, input logic [7:0] mp,
                            input logic [7:0] mc, input int exp_cyc,
                            input logic [15:0] exp_prod, input int exp_sub);
        int          cyc;
        logic [15:0] prod;
        bit          to;
        int          exp_add;
        exp_add = $countones(mp) - exp_sub;
        run_op(mp, mc, cyc, prod, to);
        tests_run++;
        if (to) begin
            fails++;
            $display("FAIL %s_timeout no done within 200 cycles", nm);
            return;
        end
        tests_run++;
        if (cyc !== exp_cyc) begin
            fails++;
            $display("FAIL %s_cycles got=%0d exp=%0d", nm, cyc, exp_cyc);
        end
        tests_run++;
        if (prod !== exp_prod) begin
            fails++;
            $display("FAIL %s_product mp=%h mc=%h got=%h exp=%h",
                     nm, mp, mc, prod, exp_prod);
        end
        tests_run++;
        if (sub_cnt !== exp_sub || add_cnt !== exp_add) begin
            fails++;
            $display("FAIL %s_addsub got=%0d/%0d exp=%0d/%0d",
                     nm, add_cnt, sub_cnt, exp_add, exp_sub);
        end
        tests_run++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_pulse got=%0d busy=%b exp=1 busy=0",
                     nm, done_cnt, busy);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  mps [4] = '{8'h03, 8'hFD, 8'h80, 8'h00};
        logic [7:0]  mcs [4] = '{8'h05, 8'h05, 8'h80, 8'h5A};
        int          cys [4] = '{30, 35, 29, 28};
        logic [15:0] prs [4] = '{16'h000F, 16'hFFF1, 16'h4000, 16'h0000};
        int          sbs [4] = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++)
            check_op($sformatf("dir%0d", i), mps[i], mcs[i], cys[i],
                     prs[i], sbs[i]);
    endtask

    task automatic test_random();
        logic [7:0]  mp;
        logic [7:0]  mc;
        logic [15:0] p;
        for (int i = 0; i < 16; i++) begin
            mp = 8'($urandom);
            mc = 8'($urandom);
            p = 16'($signed(mp) * $signed(mc));
            check_op($sformatf("rnd%0d", i), mp, mc,
                     4 + 3 * W + $countones(mp), p, int'(mp[7]));
        end
    endtask

    task automatic test_back_to_back();
        bit seen_idle;
        bit to;
        tick();
        mplier = 8'h07;
        mcand = 8'h09;
        clear_counts();
        start = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to) begin
            fails++;
            $display("FAIL held_timeout no done within 100 cycles");
        end
        tests_run++;
        if (done_cnt !== 1) begin
            fails++;
            $display("FAIL held_done_count got=%0d exp=1", done_cnt);
        end
        tests_run++;
        if ({a, x} !== 16'h003F) begin
            fails++;
            $display("FAIL held_product got=%h exp=003f", {a, x});
        end
        tick();
        seen_idle = (busy == 1'b0);
        tests_run++;
        if (!seen_idle) begin
            fails++;
            $display("FAIL held_idle got busy=%b exp=0", busy);
        end
        tick();
        tests_run++;
        if (busy !== 1'b1 || c !== 15'h000F) begin
            fails++;
            $display("FAIL held_restart got busy=%b c=%h exp busy=1 c=000f",
                     busy, c);
        end
        start = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to || done_cnt !== 2) begin
            fails++;
            $display("FAIL held_second got done_cnt=%0d exp=2", done_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit to;
        tick();
        mplier = 8'h7F;
        mcand = 8'h33;
        start = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            start = 1'b0;
            if (c[8] && c[5:4] == 2'b10 && c[10]) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to) begin
            fails++;
            $display("FAIL midreset_timeout ADD never reached");
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (c !== 15'h0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state got c=%h busy=%b done=%b exp 0/0/0",
                     c, busy, done);
        end
        reset = 1'b0;
        check_op("after_reset", 8'hC5, 8'h2B, 4 + 3 * W + $countones(8'hC5),
                 16'($signed(8'hC5) * $signed(8'h2B)), 1);
    endtask

`ifdef ROBS_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        bit to;
        tick();
        force_zq0 = 1'b1;
        mplier = 8'h01;
        mcand = 8'h11;
        clear_counts();
        err_cnt = 0;
        start = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            start = 1'b0;
            if (err || done) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to || err !== 1'b1) begin
            fails++;
            $display("FAIL wd_err got err=%b exp=1", err);
        end
        tests_run++;
        if (wr_cnt !== W || done_cnt !== 0) begin
            fails++;
            $display("FAIL wd_writes got=%0d done=%0d exp=%0d done=0",
                     wr_cnt, done_cnt, W);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || err !== 1'b0 || err_cnt !== 1) begin
            fails++;
            $display("FAIL wd_return got busy=%b err=%b errs=%0d exp 0/0/1",
                     busy, err, err_cnt);
        end
        force_zq0 = 1'b0;
        check_op("wd_after", 8'h93, 8'h0E, 4 + 3 * W + $countones(8'h93),
                 16'($signed(8'h93) * $signed(8'h0E)), 1);
    endtask
`else
    task automatic test_no_err();
        tests_run++;
        if (err_cnt !== 0) begin
            fails++;
            $display("FAIL err_quiet got=%0d exp=0", err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef ROBS_CTRL_WATCHDOG_EN
        test_watchdog();
`else
        test_no_err();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
